// File: rtl/joystick_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : joystick_pkg
// Description : Shared types and default timing constants for the joystick
//               controller, the event generator and the menu logic.
// Revision    : 1.0 - initial release
// ============================================================================
package joystick_pkg;

    // Direction code carried on evt_dir and used by downstream menu logic.
    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // Event generator state encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    // Default timing at the 1 MHz system clock.
    localparam int c_DEBOUNCE_CYCLES = 20000;   // 20 ms
    localparam int c_REPEAT_DELAY    = 500000;  // 500 ms
    localparam int c_REPEAT_PERIOD   = 150000;  // 150 ms

    // Largest of three cycle counts; sizes the shared timing counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/joystick_dir_encode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : joystick_dir_encode
// Description : Priority encoder of the raw direction flags:
//               up > down > left > right, otherwise DIR_NONE.
// Revision    : 1.0 - initial release
// ============================================================================
import joystick_pkg::*;

module joystick_dir_encode (
    input  logic i_up,
    input  logic i_down,
    input  logic i_left,
    input  logic i_right,
    output dir_t o_dir
);

    // Diagonals resolve to the higher-priority axis.
    always_comb begin
        o_dir = DIR_NONE;
        if (i_up)
            o_dir = DIR_UP;
        else if (i_down)
            o_dir = DIR_DOWN;
        else if (i_left)
            o_dir = DIR_LEFT;
        else if (i_right)
            o_dir = DIR_RIGHT;
    end

endmodule
`default_nettype wire

// File: rtl/joystick_event_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : joystick_event_gen
// Description : Turns level joystick direction flags into debounced
//               single-cycle navigation events with hold-to-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
import joystick_pkg::*;

module joystick_event_gen #(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       joystick_up,
    input  logic       joystick_down,
    input  logic       joystick_left,
    input  logic       joystick_right,
    output logic       evt_valid,
    output logic [2:0] evt_dir,
    output logic       evt_repeat,
    output logic       pressed,
    output logic [7:0] evt_count
);

    localparam int c_CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);

    // Terminal values: each phase lasts N cycles, counted 0..N-1.
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DLY_LAST = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_PER_LAST = c_CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    dir_t               w_dir_raw;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    dir_t               r_cand;
    dir_t               w_cand_nxt;
    logic               w_emit;
    logic               w_emit_rep;

    logic               r_evt_valid;
    dir_t               r_evt_dir;
    logic               r_evt_repeat;
    logic [7:0]         r_evt_count;

    joystick_dir_encode u_dir_encode (
        .i_up    (joystick_up),
        .i_down  (joystick_down),
        .i_left  (joystick_left),
        .i_right (joystick_right),
        .o_dir   (w_dir_raw)
    );

    // State, shared timing counter and latched candidate direction.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= DIR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Next-state, counter update and event decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_emit      = 1'b0;
        w_emit_rep  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dir_raw != DIR_NONE) begin
                    w_cand_nxt  = w_dir_raw;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (w_dir_raw != r_cand) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_emit      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (w_dir_raw != r_cand) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end else if (!REPEAT_EN) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_DLY_LAST) begin
                    w_emit      = 1'b1;
                    w_emit_rep  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (w_dir_raw != r_cand) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end else if (r_cnt == c_PER_LAST) begin
                    w_emit     = 1'b1;
                    w_emit_rep = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_RELEASE: begin
                // Any deflection restarts the centre-hold count, so a direct
                // switch between directions yields nothing until centred.
                if (w_dir_raw != DIR_NONE) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered event outputs and wrapping event counter.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_evt_valid  <= 1'b0;
            r_evt_dir    <= DIR_NONE;
            r_evt_repeat <= 1'b0;
            r_evt_count  <= 8'd0;
        end else begin
            r_evt_valid  <= w_emit;
            r_evt_dir    <= w_emit ? r_cand : DIR_NONE;
            r_evt_repeat <= w_emit_rep;
            if (w_emit)
                r_evt_count <= r_evt_count + 8'd1;
        end
    end

    assign evt_valid  = r_evt_valid;
    assign evt_dir    = r_evt_dir;
    assign evt_repeat = r_evt_repeat;
    assign evt_count  = r_evt_count;
    assign pressed    = (r_state == ST_HOLD) || (r_state == ST_REPEAT);

endmodule
`default_nettype wire

// File: tb/tb_joystick_event_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_joystick_event_gen
// Description : Self-checking bench for joystick_event_gen; one instance with
//               auto-repeat, one without, both against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joystick_event_gen;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic       clk_1MHz;
    logic       rst;
    logic       joystick_up, joystick_down, joystick_left, joystick_right;

    // index 0: REPEAT_EN=1, index 1: REPEAT_EN=0
    logic       o_valid [2];
    logic [2:0] o_dir   [2];
    logic       o_rep   [2];
    logic       o_press [2];
    logic [7:0] o_count [2];

    int n_checks = 0;
    int n_errors = 0;

    joystick_event_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
                         .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)) dut_rep (
        .clk_1MHz(clk_1MHz), .rst(rst),
        .joystick_up(joystick_up), .joystick_down(joystick_down),
        .joystick_left(joystick_left), .joystick_right(joystick_right),
        .evt_valid(o_valid[0]), .evt_dir(o_dir[0]), .evt_repeat(o_rep[0]),
        .pressed(o_press[0]), .evt_count(o_count[0])
    );

    joystick_event_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
                         .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)) dut_nrp (
        .clk_1MHz(clk_1MHz), .rst(rst),
        .joystick_up(joystick_up), .joystick_down(joystick_down),
        .joystick_left(joystick_left), .joystick_right(joystick_right),
        .evt_valid(o_valid[1]), .evt_dir(o_dir[1]), .evt_repeat(o_rep[1]),
        .pressed(o_press[1]), .evt_count(o_count[1])
    );

    initial clk_1MHz = 1'b0;
    always #5 clk_1MHz = ~clk_1MHz;

    // Reference model: phase 0 centred, 1 qualifying, 2 held, 3 releasing.
    // m_q counts matching samples, m_h counts held cycles since first event.
    int         m_phase [2];
    int         m_q     [2];
    int         m_h     [2];
    int         m_rel   [2];
    logic [2:0] m_cand  [2];
    logic       e_valid [2];
    logic [2:0] e_dir   [2];
    logic       e_rep   [2];
    logic       e_press [2];
    logic [7:0] e_count [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [2:0] prio(input logic u, input logic d, input logic l, input logic r);
        if (u) return 3'd1;
        if (d) return 3'd2;
        if (l) return 3'd3;
        if (r) return 3'd4;
        return 3'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_q[i] = 0; m_h[i] = 0; m_rel[i] = 0; m_cand[i] = 3'd0;
            e_valid[i] = 1'b0; e_dir[i] = 3'd0; e_rep[i] = 1'b0;
            e_press[i] = 1'b0; e_count[i] = 8'd0;
        end
    endtask

    task automatic emit(input int i, input logic is_rep);
        e_valid[i] = 1'b1;
        e_dir[i]   = m_cand[i];
        e_rep[i]   = is_rep;
        e_count[i] = e_count[i] + 8'd1;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        logic [2:0] dr;
        bit         ren;
        if (rst) begin
            model_reset();
            return;
        end
        dr = prio(joystick_up, joystick_down, joystick_left, joystick_right);
        for (int i = 0; i < 2; i++) begin
            ren = (i == 0);
            e_valid[i] = 1'b0; e_dir[i] = 3'd0; e_rep[i] = 1'b0;
            case (m_phase[i])
                0: if (dr != 3'd0) begin
                    m_cand[i] = dr; m_q[i] = 1; m_phase[i] = 1;
                end
                1: if (dr != m_cand[i]) m_phase[i] = 0;
                   else begin
                       m_q[i]++;
                       if (m_q[i] == DEB + 1) begin
                           emit(i, 1'b0); m_phase[i] = 2; m_h[i] = 0;
                       end
                   end
                2: if (dr != m_cand[i]) begin
                       m_phase[i] = 3; m_rel[i] = 0;
                   end else begin
                       m_h[i]++;
                       if (ren && m_h[i] >= RD && ((m_h[i] - RD) % RP) == 0)
                           emit(i, 1'b1);
                   end
                default: if (dr != 3'd0) m_rel[i] = 0;
                   else begin
                       m_rel[i]++;
                       if (m_rel[i] == DEB) m_phase[i] = 0;
                   end
            endcase
            e_press[i] = (m_phase[i] == 2);
        end
    endtask

    task automatic check_all();
        chk("rep.valid",   32'(o_valid[0]), 32'(e_valid[0]));
        chk("rep.dir",     32'(o_dir[0]),   32'(e_dir[0]));
        chk("rep.repeat",  32'(o_rep[0]),   32'(e_rep[0]));
        chk("rep.pressed", 32'(o_press[0]), 32'(e_press[0]));
        chk("rep.count",   32'(o_count[0]), 32'(e_count[0]));
        chk("nrp.valid",   32'(o_valid[1]), 32'(e_valid[1]));
        chk("nrp.dir",     32'(o_dir[1]),   32'(e_dir[1]));
        chk("nrp.repeat",  32'(o_rep[1]),   32'(e_rep[1]));
        chk("nrp.pressed", 32'(o_press[1]), 32'(e_press[1]));
        chk("nrp.count",   32'(o_count[1]), 32'(e_count[1]));
    endtask

    // js = {up, down, left, right}; called at a falling edge.
    task automatic cyc(input logic [3:0] js);
        {joystick_up, joystick_down, joystick_left, joystick_right} = js;
        @(posedge clk_1MHz);
        model_step();
        @(negedge clk_1MHz);
        check_all();
    endtask

    task automatic hold(input logic [3:0] js, input int n);
        for (int k = 0; k < n; k++) cyc(js);
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic do_reset(input logic [3:0] js, input int n);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        hold(js, n);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] js;
        int         len;
        rst = 1'b1;
        {joystick_up, joystick_down, joystick_left, joystick_right} = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk_1MHz);
        check_all();
        rst = 1'b0;

        // Single press of up, short enough that no repeat occurs.
        hold(4'b1000, 8);
        hold(4'b0000, 8);
        chk("s1.nrp_count", 32'(o_count[1]), 32'd1);

        // Short left glitch: no event.
        hold(4'b0010, 3);
        hold(4'b0000, 6);

        // Long right hold: first event then repeats.
        hold(4'b0001, 30);
        hold(4'b0000, 6);

        // Diagonal resolves to up; switching to left needs centre first.
        hold(4'b1010, 12);
        hold(4'b0010, 10);
        hold(4'b0000, 5);
        hold(4'b0010, 8);
        hold(4'b0000, 6);

        // Reset two cycles into HOLD with stick still held.
        hold(4'b1000, 7);
        do_reset(4'b1000, 2);
        hold(4'b1000, 10);
        hold(4'b0000, 6);

        // Randomised segments.
        for (int s = 0; s < 60; s++) begin
            js  = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom_range(1, 15));
            len = $urandom_range(1, 16);
            hold(js, len);
            if ($urandom_range(0, 29) == 0) do_reset(js, $urandom_range(1, 3));
        end
        hold(4'b0000, 6);

        // Enough presses to wrap the event counter on both instances.
        for (int p = 0; p < 260; p++) begin
            hold(4'b1000, 6);
            hold(4'b0000, 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/joystick_event_gen.md
# joystick_event_gen

Converts the level-type direction flags of the joystick controller (`joystick_up/down/left/right`) into debounced, single-cycle navigation events with hold-to-repeat. It sits directly downstream of the joystick controller and feeds menu/cursor logic driving the I2C LCD. It is fully synchronous to the 1 MHz system clock, and its inputs already come from that domain, so no input synchronisers are used.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 20000: consecutive stable cycles required to accept a press or a release (20 ms at 1 MHz); minimum 2.
- `REPEAT_DELAY`, 500000: hold cycles after the first event before auto-repeat starts; minimum 2.
- `REPEAT_PERIOD`, 150000: cycles between repeat events; minimum 2.
- `REPEAT_EN`, 1: 0 disables auto-repeat, giving one event per press.

Ports:
- `clk_1MHz`, in, 1: the single clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `joystick_up`, `joystick_down`, `joystick_left`, `joystick_right`, in, 1 each: level direction flags.
- `evt_valid`, out, 1: one-cycle event strobe.
- `evt_dir`, out, 3: direction code for the event; valid while `evt_valid` is high, otherwise `DIR_NONE`.
- `evt_repeat`, out, 1: high with `evt_valid` when the event is an auto-repeat.
- `pressed`, out, 1: level, high while a debounced press is held (states HOLD and REPEAT).
- `evt_count`, out, 8: debug count of emitted events; wraps 255 to 0.

## Operation
- `dir_raw` is a combinational priority encode: up > down > left > right, else `DIR_NONE`. A diagonal input resolves to the higher-priority axis.
- FSM states are IDLE, DEBOUNCE, HOLD, REPEAT and RELEASE. A single counter `cnt` is used; `cand` is the latched candidate direction.
- IDLE:
  - If `dir_raw` is `DIR_NONE`, stay.
  - Otherwise set `cand <= dir_raw`, `cnt <= 0`, and go to DEBOUNCE.
- DEBOUNCE:
  - If `dir_raw != cand`, return to IDLE with no event.
  - Else increment `cnt`. When `cnt == DEBOUNCE_CYCLES-1`: emit an event (`cand`, `repeat=0`), set `cnt <= 0`, and go to HOLD.
- HOLD:
  - If `dir_raw != cand`, go to RELEASE with `cnt <= 0`.
  - Else, if `REPEAT_EN`, increment `cnt`. At `REPEAT_DELAY-1`: emit an event (`repeat=1`), set `cnt <= 0`, and go to REPEAT.
  - If `REPEAT_EN == 0`, `cnt` holds at 0.
- REPEAT:
  - If `dir_raw != cand`, go to RELEASE with `cnt <= 0`.
  - Else increment `cnt`. At `REPEAT_PERIOD-1`: emit an event (`repeat=1`) and set `cnt <= 0`.
- RELEASE:
  - Requires `dir_raw == DIR_NONE` for `DEBOUNCE_CYCLES` consecutive cycles before returning to IDLE.
  - Any non-NONE sample clears `cnt` and the FSM stays in RELEASE.
  - Consequence: a direct change from one direction to another produces no event until the stick returns to centre.
- Emitting an event registers `evt_valid=1`, `evt_dir=cand`, `evt_repeat` as above, and `evt_count <= evt_count+1` (mod 256). In all other cycles `evt_valid=0`, `evt_dir=DIR_NONE`, `evt_repeat=0`.
- Counter width is `$clog2` of the maximum of the three cycle parameters. The counter never exceeds its terminal value.

## Timing
- Reset (asynchronous, immediate): state IDLE; `cnt=0`; `cand=DIR_NONE`; `evt_valid=0`; `evt_dir=DIR_NONE`; `evt_repeat=0`; `pressed=0`; `evt_count=0`.
- Reset asserted mid-press or mid-repeat aborts without emitting an event. After deassertion with the stick still held, a fresh full debounce is required.
- First event latency: if `dir_raw` first becomes non-NONE at edge E0 and stays stable, `evt_valid` is high for exactly the one cycle after edge E0+`DEBOUNCE_CYCLES`.
- First repeat: `REPEAT_DELAY` cycles after the first event. Later repeats: every `REPEAT_PERIOD` cycles.
- `pressed` rises in the same cycle as the first `evt_valid`. It falls on the first cycle in RELEASE, one cycle after `dir_raw` leaves `cand`.
- A glitch shorter than `DEBOUNCE_CYCLES` in IDLE/DEBOUNCE produces no event. A glitch in RELEASE restarts the release count.
- There is no backpressure: consumers must sample `evt_valid` every cycle.

## Structure
- Package `joystick_pkg` holds:
  - the `dir_t` encoding: `DIR_NONE`=0, `DIR_UP`=1, `DIR_DOWN`=2, `DIR_LEFT`=3, `DIR_RIGHT`=4;
  - the FSM state encoding;
  - the default timing constants.
- The package is shared with the joystick controller and the menu logic.
- One natural sub-module is `joystick_dir_encode`, the combinational priority encoder. Everything else stays in one always-block FSM plus the output register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Hold `up` for 8 cycles with `REPEAT_EN`=0, then release → exactly one `evt_valid`, in the cycle after edge E0+4, with `evt_dir`=1 and `evt_repeat`=0; `evt_count`=1.
- Pulse `left` high for 3 cycles, then low → no event; state returns to IDLE; `pressed` stays 0.
- Hold `right` for 30 cycles with `REPEAT_EN`=1 → events at E0+4 (`repeat`=0), E0+14, E0+17, E0+20, … (`repeat`=1); all have `evt_dir`=4.
- Assert `up` and `left` together, stable → events carry `evt_dir`=1. Then drop `up` while holding `left` → `pressed` falls and no `left` event occurs until centre is held for 4 cycles and `left` is re-debounced.
- Assert `rst` 2 cycles into HOLD → all outputs reset immediately. With the stick still held after release of `rst`, the next event arrives 4+1 cycles later.
- Generate 256 events → `evt_count` wraps to 0.
